// File: rtl/frame_pad_stream.sv
// frame_pad_stream: surrounds a raster pixel stream with a border of (kernelSize-1)/2 pixels per side.
// Optional macro PAD_CONST_EN: border pixels come from iPadValue (latched at newFrame); otherwise zero.
module frame_pad_stream #(
    parameter int width      = 1920,
    parameter int height     = 1080,
    parameter int kernelSize = 7,
    parameter int channels   = 3,
    parameter int dataWidth  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          newFrame,
    input  logic                          iValid,
    input  logic [channels*dataWidth-1:0] iData,
    output logic                          oReady,
`ifdef PAD_CONST_EN
    input  logic [channels*dataWidth-1:0] iPadValue,
`endif
    output logic                          oValid,
    output logic [channels*dataWidth-1:0] oData,
    input  logic                          iReady,
    output logic [31:0]                   oXCnt,
    output logic [31:0]                   oYCnt,
    output logic                          oBusy,
    output logic                          oDone
);

    localparam int pixelWidth = channels * dataWidth;
    localparam int border     = (kernelSize - 1) / 2;

    localparam logic [31:0] lastCol     = 32'(width + 2 * border - 1);
    localparam logic [31:0] lastRow     = 32'(height + 2 * border - 1);
    localparam logic [31:0] lastTopRow  = 32'(border - 1);
    localparam logic [31:0] lastLeftCol = 32'(border - 1);
    localparam logic [31:0] lastDataCol = 32'(border + width - 1);
    localparam logic [31:0] lastDataRow = 32'(border + height - 1);

    typedef enum logic [2:0] {IDLE, TOP, LEFT, DATA, RIGHT, BOTTOM, DONE} stateT;

    stateT                 state, nextState;
    logic [31:0]           xPos, yPos;      // coordinates of the next pixel to be emitted
    logic                  load, emit;
    logic [pixelWidth-1:0] pixel, borderPixel;

`ifdef PAD_CONST_EN
    logic [pixelWidth-1:0] padReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            padReg <= '0;
        else if (state == IDLE && newFrame)
            padReg <= iPadValue;
    end

    assign borderPixel = padReg;
`else
    assign borderPixel = '0;
`endif

    assign load   = !oValid || iReady;
    assign oReady = (state == DATA) && load;
    assign oBusy  = (state != IDLE);
    // The pulse waits until the final pixel has actually left the output register.
    assign oDone  = (state == DONE) && !oValid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nextState = state;
        emit      = 1'b0;
        pixel     = borderPixel;
        case (state)
            IDLE: begin
                if (newFrame) nextState = TOP;
            end
            TOP: begin
                if (load) begin
                    emit = 1'b1;
                    if (xPos == lastCol && yPos == lastTopRow) nextState = LEFT;
                end
            end
            LEFT: begin
                if (load) begin
                    emit = 1'b1;
                    if (xPos == lastLeftCol) nextState = DATA;
                end
            end
            DATA: begin
                if (iValid && load) begin
                    emit  = 1'b1;
                    pixel = iData;
                    if (xPos == lastDataCol) nextState = RIGHT;
                end
            end
            RIGHT: begin
                if (load) begin
                    emit = 1'b1;
                    if (xPos == lastCol) nextState = (yPos == lastDataRow) ? BOTTOM : LEFT;
                end
            end
            BOTTOM: begin
                if (load) begin
                    emit = 1'b1;
                    if (xPos == lastCol && yPos == lastRow) nextState = DONE;
                end
            end
            DONE: begin
                if (!oValid) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            oValid <= 1'b0;
            oData  <= '0;
            oXCnt  <= '0;
            oYCnt  <= '0;
            xPos   <= '0;
            yPos   <= '0;
        end else begin
            state <= nextState;
            if (emit) begin
                oValid <= 1'b1;
                oData  <= pixel;
                oXCnt  <= xPos;
                oYCnt  <= yPos;
                if (xPos == lastCol) begin
                    xPos <= '0;
                    yPos <= yPos + 32'd1;
                end else begin
                    xPos <= xPos + 32'd1;
                end
            end else if (iReady) begin
                oValid <= 1'b0;
            end
            if (state == IDLE) begin
                xPos  <= '0;
                yPos  <= '0;
                oXCnt <= '0;
                oYCnt <= '0;
                oData <= '0;
            end
        end
    end

endmodule
